// File: rtl/write_buffer_pkg.sv
// Shared cache constants and the write-buffer controller state encoding.
package write_buffer_pkg;
    localparam int BLOCK_AW         = 28;
    localparam int BLOCK_DW         = 128;
    localparam int WB_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        WB_IDLE   = 2'd0,
        WB_MEM_RD = 2'd1,
        WB_MEM_WR = 2'd2,
        WB_RESP   = 2'd3
    } wb_state_e;
endpackage

// File: rtl/write_buffer_fifo.sv
// Circular store of pending block writes with a youngest-match address lookup.
module wb_fifo
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                coalesce,
    input  logic                pop,
    input  logic [BLOCK_AW-1:0] wr_addr,
    input  logic [BLOCK_DW-1:0] wr_data,
    input  logic [BLOCK_AW-1:0] lookup_addr,
    output logic                hit,
    output logic [BLOCK_DW-1:0] hit_data,
    output logic [BLOCK_AW-1:0] head_addr,
    output logic [BLOCK_DW-1:0] head_data,
    output logic                full,
    output logic                empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]       head_reg;
    logic [PW-1:0]       tail_reg;
    logic [CW-1:0]       count_reg;
    logic [DEPTH-1:0]    slot_match;
    logic [BLOCK_AW-1:0] slot_addr [DEPTH];
    logic [BLOCK_DW-1:0] slot_data [DEPTH];
    logic [PW-1:0]       hit_idx;
    logic [PW-1:0]       scan_idx;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic                valid_reg;
            logic [BLOCK_AW-1:0] addr_reg;
            logic [BLOCK_DW-1:0] data_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                end else if (push && tail_reg == PW'(gi)) begin
                    valid_reg <= 1'b1;
                end else if (pop && head_reg == PW'(gi)) begin
                    valid_reg <= 1'b0;
                end
            end

            // Payload needs no reset: it is only ever observed through valid_reg.
            always_ff @(posedge clk) begin
                if (push && tail_reg == PW'(gi)) begin
                    addr_reg <= wr_addr;
                    data_reg <= wr_data;
                end else if (coalesce && hit_idx == PW'(gi)) begin
                    data_reg <= wr_data;
                end
            end

            assign slot_match[gi] = valid_reg && (addr_reg == lookup_addr);
            assign slot_addr[gi]  = addr_reg;
            assign slot_data[gi]  = data_reg;
        end
    endgenerate

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        scan_idx = head_reg;
        for (int k = 0; k < DEPTH; k++) begin
            if (slot_match[scan_idx]) begin
                hit     = 1'b1;
                hit_idx = scan_idx;
            end
            scan_idx = ptr_inc(scan_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign hit_data  = slot_data[hit_idx];
    assign head_addr = slot_addr[head_reg];
    assign head_data = slot_data[head_reg];
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
endmodule

// File: rtl/write_buffer.sv
// Write buffer between cache and memory: buffers block writes, serves reads
// from pending writes, and drains one entry at a time to memory.
module write_buffer
    import write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                proc_reset,
    input  logic                c_read,
    input  logic                c_write,
    input  logic [BLOCK_AW-1:0] c_addr,
    input  logic [BLOCK_DW-1:0] c_wdata,
    output logic [BLOCK_DW-1:0] c_rdata,
    output logic                c_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic [BLOCK_AW-1:0] mem_addr,
    output logic [BLOCK_DW-1:0] mem_wdata,
    input  logic [BLOCK_DW-1:0] mem_rdata,
    input  logic                mem_ready
);
    wb_state_e           state_reg, state_next;
    logic [BLOCK_AW-1:0] rd_addr_reg, rd_addr_next;
    logic [BLOCK_DW-1:0] rdata_reg, rdata_next;

    logic                fifo_push;
    logic                fifo_coalesce;
    logic                fifo_pop;
    logic                hit;
    logic [BLOCK_DW-1:0] hit_data;
    logic [BLOCK_AW-1:0] head_addr;
    logic [BLOCK_DW-1:0] head_data;
    logic                full;
    logic                empty;

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (proc_reset),
        .push       (fifo_push),
        .coalesce   (fifo_coalesce),
        .pop        (fifo_pop),
        .wr_addr    (c_addr),
        .wr_data    (c_wdata),
        .lookup_addr(c_addr),
        .hit        (hit),
        .hit_data   (hit_data),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty)
    );

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_reg   <= WB_IDLE;
            rd_addr_reg <= '0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            rd_addr_reg <= rd_addr_next;
            rdata_reg   <= rdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        rd_addr_next  = rd_addr_reg;
        rdata_next    = rdata_reg;
        fifo_push     = 1'b0;
        fifo_coalesce = 1'b0;
        fifo_pop      = 1'b0;
        case (state_reg)
            WB_IDLE: begin
                if (c_read && hit) begin
                    rdata_next = hit_data;
                    state_next = WB_RESP;
                end else if (c_read) begin
                    rd_addr_next = c_addr;
                    state_next   = WB_MEM_RD;
                end else if (c_write && hit) begin
                    fifo_coalesce = 1'b1;
                    rdata_next    = '0;
                    state_next    = WB_RESP;
                end else if (c_write && !full) begin
                    fifo_push  = 1'b1;
                    rdata_next = '0;
                    state_next = WB_RESP;
                end else if (!empty) begin
                    // A write blocked on a full buffer also lands here.
                    state_next = WB_MEM_WR;
                end
            end
            WB_MEM_RD: begin
                if (mem_ready) begin
                    rdata_next = mem_rdata;
                    state_next = WB_RESP;
                end
            end
            WB_MEM_WR: begin
                if (mem_ready) begin
                    fifo_pop = 1'b1;
                    // The drained head is still visible to the lookup this cycle.
                    if (c_read && hit) begin
                        rdata_next = hit_data;
                        state_next = WB_RESP;
                    end else begin
                        state_next = WB_IDLE;
                    end
                end
            end
            WB_RESP: begin
                state_next = WB_IDLE;
            end
            default: begin
                state_next = WB_IDLE;
            end
        endcase
    end

    assign c_ready   = (state_reg == WB_RESP);
    assign c_rdata   = c_ready ? rdata_reg : '0;
    assign mem_read  = (state_reg == WB_MEM_RD);
    assign mem_write = (state_reg == WB_MEM_WR);
    assign mem_addr  = mem_read ? rd_addr_reg : (mem_write ? head_addr : '0);
    assign mem_wdata = mem_write ? head_data : '0;
endmodule

// File: tb/tb_write_buffer.sv
// Scoreboard bench for write_buffer: a shadow memory predicts every read,
// a memory responder services the DUT, and a monitor checks each c_ready.
module tb_write_buffer;
    import write_buffer_pkg::*;

    typedef logic [BLOCK_AW-1:0] addr_t;
    typedef logic [BLOCK_DW-1:0] data_t;
    typedef struct {
        bit    is_read;
        addr_t addr;
        data_t data;
    } exp_t;
    typedef struct {
        bit    is_write;
        addr_t addr;
        data_t data;
    } memop_t;

    logic  clk        = 1'b0;
    logic  proc_reset = 1'b1;
    logic  c_read     = 1'b0;
    logic  c_write    = 1'b0;
    addr_t c_addr     = '0;
    data_t c_wdata    = '0;
    data_t mem_rdata  = '0;
    logic  mem_ready  = 1'b0;
    data_t c_rdata;
    logic  c_ready;
    logic  mem_read;
    logic  mem_write;
    addr_t mem_addr;
    data_t mem_wdata;

    int     n_cmp     = 0;
    int     n_fail    = 0;
    int     n_mem_rd  = 0;
    int     n_mem_wr  = 0;
    int     fixed_lat = -1;
    int     force_req = 0;
    exp_t   exp_q[$];
    memop_t op_q[$];
    data_t  shadow[addr_t];
    data_t  mem_store[addr_t];

    write_buffer dut (
        .clk       (clk),
        .proc_reset(proc_reset),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_addr    (c_addr),
        .c_wdata   (c_wdata),
        .c_rdata   (c_rdata),
        .c_ready   (c_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    function automatic data_t init_word(input addr_t a);
        logic [31:0] w;
        w = 32'hA5C3_0000 ^ {4'h0, a};
        return {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'd7};
    endfunction

    function automatic data_t rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input data_t act, input data_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Issue one cache request; the expected response is queued before driving.
    task automatic issue(input bit is_read, input addr_t a, input data_t d, output int cycles);
        exp_t e;
        e.is_read = is_read;
        e.addr    = a;
        if (is_read) begin
            e.data = shadow.exists(a) ? shadow[a] : init_word(a);
        end else begin
            e.data    = d;
            shadow[a] = d;
        end
        exp_q.push_back(e);
        c_addr  = a;
        c_wdata = is_read ? '0 : d;
        c_read  = is_read;
        c_write = !is_read;
        cycles  = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (c_ready) begin
                cycles = i;
                break;
            end
        end
        c_read  = 1'b0;
        c_write = 1'b0;
        if (cycles == 0) begin
            check("c_ready_timeout", data_t'(c_ready), data_t'(1));
            void'(exp_q.pop_back());
        end
        $display("txn %s addr=%h data=%h cycles=%0d", is_read ? "RD" : "WR", a, e.data, cycles);
    endtask

    task automatic wait_quiet();
        int quiet;
        quiet = 0;
        for (int i = 0; i < 500 && quiet < 4; i++) begin
            @(negedge clk);
            if (mem_read || mem_write || c_ready) quiet = 0;
            else quiet++;
        end
        checki("drain_quiet", quiet, 4);
    endtask

    task automatic apply_reset();
        proc_reset = 1'b1;
        c_read     = 1'b0;
        c_write    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_c_ready", data_t'(c_ready), '0);
        check("rst_mem_rw", data_t'({mem_read, mem_write}), '0);
        check("rst_c_rdata", c_rdata, '0);
        check("rst_mem_addr", data_t'(mem_addr), '0);
        check("rst_mem_wdata", mem_wdata, '0);
        proc_reset = 1'b0;
        @(negedge clk);
    endtask

    // Monitor: pop and compare on every completion, plus memory-side rules.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("mem_rd_wr_exclusive", data_t'(mem_read && mem_write), '0);
            check("mem_wdata_idle_zero", mem_write ? '0 : mem_wdata, '0);
            if (!proc_reset && c_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_c_ready", data_t'(c_ready), '0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_read) check($sformatf("rdata@%h", e.addr), c_rdata, e.data);
                end
            end
        end
    end

    // Memory responder with fixed or random latency and a stray-strobe hook.
    initial begin
        int     wait_cnt;
        int     force_seen;
        memop_t op;
        wait_cnt   = -1;
        force_seen = 0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            mem_rdata = '0;
            if (proc_reset) begin
                wait_cnt = -1;
            end else if (force_req != force_seen) begin
                force_seen = force_req;
                mem_ready  = 1'b1;
            end else if (mem_read || mem_write) begin
                if (wait_cnt < 0) wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                if (wait_cnt == 0) begin
                    mem_ready   = 1'b1;
                    op.is_write = mem_write;
                    op.addr     = mem_addr;
                    op.data     = mem_wdata;
                    op_q.push_back(op);
                    if (mem_read) begin
                        n_mem_rd++;
                        mem_rdata = mem_store.exists(mem_addr) ? mem_store[mem_addr] : init_word(mem_addr);
                    end else begin
                        n_mem_wr++;
                        mem_store[mem_addr] = mem_wdata;
                    end
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cyc;
        int    rd0;
        int    wr0;
        int    act;
        addr_t a;
        data_t da;
        data_t db;
        apply_reset();

        // Write then immediate read hit.
        fixed_lat = 2;
        da = rand128();
        issue(1'b0, 28'h10, da, cyc);
        checki("wr_latency", cyc, 1);
        rd0 = n_mem_rd;
        issue(1'b1, 28'h10, '0, cyc);
        checki("hit_latency", cyc, 2);
        checki("hit_no_mem_read", n_mem_rd - rd0, 0);
        wait_quiet();

        // Coalesce two writes to the same block.
        op_q.delete();
        wr0 = n_mem_wr;
        da = rand128();
        db = rand128();
        issue(1'b0, 28'h10, da, cyc);
        issue(1'b0, 28'h10, db, cyc);
        wait_quiet();
        checki("coalesce_wr_count", n_mem_wr - wr0, 1);
        if (op_q.size() == 1) begin
            check("coalesce_addr", data_t'(op_q[0].addr), data_t'(28'h10));
            check("coalesce_data", op_q[0].data, db);
        end

        // Full buffer with a stalled memory, then a fifth write.
        fixed_lat = 10;
        op_q.delete();
        for (int i = 0; i < 4; i++) issue(1'b0, 28'h50 + 28'(i), rand128(), cyc);
        wr0 = n_mem_wr;
        issue(1'b0, 28'h54, rand128(), cyc);
        checki("full_accept_after_one_drain", n_mem_wr - wr0, 1);
        wait_quiet();
        checki("full_drain_count", op_q.size(), 5);
        for (int i = 0; i < 5 && i < op_q.size(); i++) begin
            check($sformatf("drain_order_%0d", i), data_t'(op_q[i].addr), data_t'(28'h50 + 28'(i)));
        end

        // Read miss takes priority over a pending drain.
        fixed_lat = 3;
        op_q.delete();
        issue(1'b0, 28'h20, rand128(), cyc);
        issue(1'b1, 28'h30, '0, cyc);
        checki("miss_first_op_is_read", (op_q.size() > 0) ? int'(!op_q[0].is_write) : 0, 1);
        if (op_q.size() > 0) check("miss_addr", data_t'(op_q[0].addr), data_t'(28'h30));
        wait_quiet();

        // Read hit on the entry being drained.
        fixed_lat = 5;
        rd0 = n_mem_rd;
        wr0 = n_mem_wr;
        issue(1'b0, 28'h20, rand128(), cyc);
        for (int i = 0; i < 50 && !mem_write; i++) @(negedge clk);
        checki("drain_started", int'(mem_write), 1);
        issue(1'b1, 28'h20, '0, cyc);
        checki("drain_hit_no_mem_read", n_mem_rd - rd0, 0);
        checki("drain_hit_after_completion", n_mem_wr - wr0, 1);
        wait_quiet();

        // Reset in the middle of a drain, followed by a stray mem_ready.
        fixed_lat = 40;
        wr0 = n_mem_wr;
        issue(1'b0, 28'h40, rand128(), cyc);
        for (int i = 0; i < 50 && !mem_write; i++) @(negedge clk);
        checki("rst_drain_started", int'(mem_write), 1);
        #1 proc_reset = 1'b1;
        #1;
        check("async_rst_mem_write", data_t'(mem_write), '0);
        check("async_rst_mem_addr", data_t'(mem_addr), '0);
        check("async_rst_mem_wdata", mem_wdata, '0);
        shadow.delete(28'h40);
        repeat (2) @(negedge clk);
        proc_reset = 1'b0;
        @(negedge clk);
        #1 force_req++;
        act = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (mem_read || mem_write || c_ready) act++;
        end
        checki("late_ready_no_activity", act, 0);
        checki("late_ready_no_mem_write", n_mem_wr - wr0, 0);

        // Random traffic over a small address set.
        fixed_lat = -1;
        for (int i = 0; i < 300; i++) begin
            a = 28'h100 + 28'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) issue(1'b1, a, '0, cyc);
            else issue(1'b0, a, rand128(), cyc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_quiet();
        foreach (shadow[k]) begin
            check($sformatf("final_mem@%h", k), mem_store.exists(k) ? mem_store[k] : init_word(k), shadow[k]);
        end
        checki("scoreboard_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/write_buffer.md
WRITE_BUFFER -- requirements
Module: write_buffer

Interface
REQ-001 Parameter DEPTH, default 4, is the number of buffered block-write entries (power of two, at least 2).
REQ-002 clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-003 proc_reset  input  1  is the reset, asynchronous and active-high.
REQ-004 c_read  input  1  is a cache block-read request, held high until c_ready.
REQ-005 c_write  input  1  is a cache block-write request, held high until c_ready.
REQ-006 c_addr  input  28  is the cache block address.
REQ-007 c_wdata  input  128  is the cache write block.
REQ-008 c_rdata  output  128  is the read block, valid while c_ready is high on a read.
REQ-009 c_ready  output  1  is a one-cycle completion pulse for the current cache request.
REQ-010 mem_read, mem_write  output  1 each  are memory requests, held high until mem_ready.
REQ-011 mem_addr  output  28  is the memory block address.
REQ-012 mem_wdata  output  128  is the memory write block.
REQ-013 mem_rdata  input  128  is the memory read block, valid with mem_ready.
REQ-014 mem_ready  input  1  is the memory completion strobe.

Function
REQ-015 The buffer SHALL be a circular FIFO of DEPTH entries {addr, data}, with head and tail pointers and a count of width clog2(DEPTH)+1.
REQ-016 The FSM SHALL have four states: IDLE, MEM_RD, MEM_WR and RESP; only one memory transaction SHALL be outstanding at a time.
REQ-017 Write accept: when c_write is high in IDLE and the buffer is not full, the buffer SHALL enqueue the write, or coalesce it per REQ-018, then go to RESP; c_ready SHALL pulse on the next cycle.
REQ-018 Coalescing: if c_addr matches a valid entry that is not currently being drained, that entry's data SHALL be overwritten and count SHALL stay unchanged.
REQ-019 Full with no coalescing match: the write SHALL wait in IDLE until a drain frees a slot, with c_ready held low.
REQ-020 Read hit: if c_addr matches any valid entry, including the entry being drained, the youngest matching entry's data SHALL be returned on c_rdata with c_ready one cycle later, without any memory access.
REQ-021 Read miss: the buffer SHALL enter MEM_RD and drive mem_read with mem_addr=c_addr; on mem_ready it SHALL latch mem_rdata and go to RESP, and c_ready SHALL pulse the next cycle.
REQ-022 Drain: in IDLE with count>0 and no pending read miss, the buffer SHALL enter MEM_WR and drive mem_write with the head entry; on mem_ready it SHALL pop the head and return to IDLE.
REQ-023 Priority in IDLE SHALL be: read hit, then read miss, then cache write, then drain.
REQ-024 A drain in progress SHALL NOT be aborted; cache requests SHALL wait for it to finish.
REQ-025 RESP SHALL last exactly one cycle and then return to IDLE.
REQ-026 Pointers SHALL wrap from DEPTH-1 to 0.
REQ-027 Full SHALL be count==DEPTH and empty SHALL be count==0.
REQ-028 mem_read and mem_write SHALL never be asserted together.
REQ-029 mem_wdata SHALL be zero when mem_write is low.

Reset
REQ-030 While proc_reset is high, the buffer SHALL be in IDLE with count, head and tail at 0 and all entries invalid.
REQ-031 While proc_reset is high, c_ready, mem_read, mem_write, c_rdata, mem_addr and mem_wdata SHALL all be 0.
REQ-032 Reset asserted mid-transaction SHALL discard buffered writes and the outstanding memory request; a mem_ready arriving after reset SHALL be ignored.

Structure
REQ-033 The state encoding, the BLOCK_AW=28 and BLOCK_DW=128 constants and the DEPTH default SHALL live in the shared cache package.
REQ-034 The entry array, the pointers and the youngest-match compare SHALL be one sub-module, wb_fifo; the FSM SHALL stay in write_buffer.

Verification
REQ-035 Write then immediate read: write addr 0x10 with data A, then read 0x10 -> c_ready 1 cycle later, c_rdata=A, no mem_read.
REQ-036 Coalesce: write 0x10 with data A, then write 0x10 with data B before the drain -> count stays 1, one mem_write of B to 0x10.
REQ-037 Full: 4 writes to distinct addresses, memory stalls 10 cycles, then a 5th write -> its c_ready is low until the first mem_ready, then it is accepted and the pointer wraps.
REQ-038 Read miss during pending drain: buffer holds 0x20 while idle, then read 0x30 -> mem_read issued before mem_write; c_rdata=mem_rdata.
REQ-039 Read hit on the entry being drained: read 0x20 during MEM_WR of 0x20 -> waits for completion, returns buffered data, and memory sees no read.
REQ-040 Reset mid-MEM_WR: outputs go to 0 asynchronously, count=0, and a late mem_ready causes no pop and no c_ready.
